// File: rtl/lock_pkg.sv
// Shared encodings and constants for the passcode lock sequencer.
package lock_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned STATE_W = 3;
  localparam int unsigned MODE_W  = 2;

  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t S_IDLE     = 3'd0;
  localparam state_t S_PROG     = 3'd1;
  localparam state_t S_ARMED    = 3'd2;
  localparam state_t S_ENTRY    = 3'd3;
  localparam state_t S_CHECK    = 3'd4;
  localparam state_t S_UNLOCKED = 3'd5;
  localparam state_t S_ALARM    = 3'd6;

  localparam logic [MODE_W-1:0] MODE_NONE  = 2'b00;
  localparam logic [MODE_W-1:0] MODE_PROG  = 2'b10;
  localparam logic [MODE_W-1:0] MODE_ENTRY = 2'b01;

  // True for a legal keypad digit 0..9.
  function automatic logic is_bcd(input logic [DIGIT_W-1:0] d);
    return (d <= BCD_MAX);
  endfunction

endpackage

// File: rtl/lock_attempt_ctr.sv
// BCD failed-attempt counter; saturates at MAX_ATTEMPTS.
module lock_attempt_ctr
  import lock_pkg::*;
#(
  parameter int unsigned MAX_ATTEMPTS = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inc,
  input  logic               clr,
  output logic [DIGIT_W-1:0] count,
  output logic               term_c,
  output logic               last_c
);

  // term_c: count has reached the limit; last_c: the next increment reaches it.
  assign term_c = (count == DIGIT_W'(MAX_ATTEMPTS));
  assign last_c = (count == DIGIT_W'(MAX_ATTEMPTS - 1));

  // Clear wins over increment; increments stop once the limit is reached.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !term_c) begin
      count <= (count == BCD_MAX) ? '0 : count + DIGIT_W'(1);
    end
  end

endmodule

// File: rtl/passcode_lock_seq.sv
// Keypad sequencer for the 8-digit passcode lock datapath.
module passcode_lock_seq
  import lock_pkg::*;
#(
  parameter int unsigned DIGITS       = 8,
  parameter int unsigned MAX_ATTEMPTS = 5,
  parameter int unsigned UNLOCK_HOLD  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               key_valid,
  input  logic [DIGIT_W-1:0] key_digit,
  input  logic               prog_req,
  input  logic               cancel,
  input  logic               alarm_rst,
  input  logic               match,
  output logic               sp_shift,
  output logic               ui_shift,
  output logic [DIGIT_W-1:0] shift_data,
  output logic               sp_clr,
  output logic               ui_clr,
  output logic [MODE_W-1:0]  mode,
  output logic [3:0]         digit_cnt,
  output logic [DIGIT_W-1:0] attempt_bcd,
  output logic               unlocked,
  output logic               alarm
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned HOLD_W = (UNLOCK_HOLD > 1) ? $clog2(UNLOCK_HOLD) : 1;

  state_t              state_q, state_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                sp_shift_d, ui_shift_d, sp_clr_d, ui_clr_d;
  logic [DIGIT_W-1:0]  shift_data_d;
  logic [MODE_W-1:0]   mode_d;
  logic [CNT_W-1:0]    digit_cnt_d;
  logic                unlocked_d, alarm_d;
  logic                att_inc, att_clr, att_term_c, att_last_c;
  logic                key_ok, last_key, entry_full, hold_done;

  assign key_ok     = key_valid && is_bcd(key_digit);
  assign last_key   = (digit_cnt == CNT_W'(DIGITS - 1));
  assign entry_full = (digit_cnt == CNT_W'(DIGITS));
  assign hold_done  = (hold_q == HOLD_W'(UNLOCK_HOLD - 1));

  lock_attempt_ctr #(.MAX_ATTEMPTS(MAX_ATTEMPTS)) u_attempt_ctr (
    .clk    (clk),
    .rst    (rst),
    .inc    (att_inc),
    .clr    (att_clr),
    .count  (attempt_bcd),
    .term_c (att_term_c),
    .last_c (att_last_c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode; priority alarm_rst > cancel > prog_req > key_valid.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:     if (prog_req) state_d = S_PROG;
      S_PROG: begin
        if (cancel)                  state_d = S_IDLE;
        else if (key_ok && last_key) state_d = S_ARMED;
      end
      S_ARMED:    if (key_ok) state_d = S_ENTRY;
      S_ENTRY: begin
        if (cancel)          state_d = S_ARMED;
        else if (entry_full) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (match)           state_d = S_UNLOCKED;
        else if (att_last_c) state_d = S_ALARM;
        else                 state_d = S_ARMED;
      end
      S_UNLOCKED: begin
        if (prog_req)       state_d = S_PROG;
        else if (hold_done) state_d = S_ARMED;
      end
      S_ALARM:    if (alarm_rst) state_d = S_ARMED;
      default:    state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs, counters and timer.
  always_comb begin
    sp_shift_d   = 1'b0;
    ui_shift_d   = 1'b0;
    sp_clr_d     = 1'b0;
    ui_clr_d     = 1'b0;
    shift_data_d = shift_data;
    digit_cnt_d  = digit_cnt;
    unlocked_d   = unlocked;
    alarm_d      = alarm;
    hold_d       = hold_q;
    att_inc      = 1'b0;
    att_clr      = 1'b0;

    unique case (state_q)
      S_IDLE: if (prog_req) digit_cnt_d = '0;
      S_PROG: begin
        if (cancel) begin
          sp_clr_d    = 1'b1;
          digit_cnt_d = '0;
        end else if (key_ok) begin
          sp_shift_d   = 1'b1;
          shift_data_d = key_digit;
          digit_cnt_d  = last_key ? '0 : digit_cnt + CNT_W'(1);
        end
      end
      S_ARMED: if (key_ok) begin
        ui_shift_d   = 1'b1;
        shift_data_d = key_digit;
        digit_cnt_d  = CNT_W'(1);
      end
      S_ENTRY: begin
        if (cancel) begin
          ui_clr_d    = 1'b1;
          digit_cnt_d = '0;
        end else if (key_ok && !entry_full) begin
          ui_shift_d   = 1'b1;
          shift_data_d = key_digit;
          digit_cnt_d  = digit_cnt + CNT_W'(1);
        end
      end
      S_CHECK: begin
        digit_cnt_d = '0;
        if (match) begin
          unlocked_d = 1'b1;
          att_clr    = 1'b1;
          hold_d     = '0;
        end else begin
          att_inc  = !att_term_c;
          ui_clr_d = 1'b1;
          alarm_d  = att_last_c;
        end
      end
      S_UNLOCKED: begin
        if (prog_req) begin
          sp_clr_d    = 1'b1;
          ui_clr_d    = 1'b1;
          unlocked_d  = 1'b0;
          digit_cnt_d = '0;
        end else if (hold_done) begin
          unlocked_d = 1'b0;
          ui_clr_d   = 1'b1;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      S_ALARM: if (alarm_rst) begin
        alarm_d  = 1'b0;
        att_clr  = 1'b1;
        ui_clr_d = 1'b1;
      end
      default: ;
    endcase

    unique case (state_d)
      S_PROG:  mode_d = MODE_PROG;
      S_ENTRY: mode_d = MODE_ENTRY;
      default: mode_d = MODE_NONE;
    endcase
  end

  // Output and datapath registers; reset pulses both array clears.
  always_ff @(posedge clk) begin
    if (rst) begin
      sp_shift   <= 1'b0;
      ui_shift   <= 1'b0;
      sp_clr     <= 1'b1;
      ui_clr     <= 1'b1;
      shift_data <= '0;
      mode       <= MODE_NONE;
      digit_cnt  <= '0;
      unlocked   <= 1'b0;
      alarm      <= 1'b0;
      hold_q     <= '0;
    end else begin
      sp_shift   <= sp_shift_d;
      ui_shift   <= ui_shift_d;
      sp_clr     <= sp_clr_d;
      ui_clr     <= ui_clr_d;
      shift_data <= shift_data_d;
      mode       <= mode_d;
      digit_cnt  <= digit_cnt_d;
      unlocked   <= unlocked_d;
      alarm      <= alarm_d;
      hold_q     <= hold_d;
    end
  end

endmodule

// File: tb/tb_passcode_lock_seq.sv
// Directed bench for passcode_lock_seq with a shift-array/comparator model.
module tb_passcode_lock_seq;
  import lock_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_digit = 4'd0;
  logic       prog_req = 1'b0;
  logic       cancel = 1'b0;
  logic       alarm_rst = 1'b0;
  logic       match;
  logic       sp_shift, ui_shift, sp_clr, ui_clr, unlocked, alarm;
  logic [3:0] shift_data, digit_cnt, attempt_bcd;
  logic [1:0] mode;

  int checks = 0;
  int errors = 0;

  logic [31:0] sp_arr = '0;
  logic [31:0] ui_arr = '0;
  logic [3:0]  code [8];

  always #5 clk = ~clk;

  passcode_lock_seq dut (
    .clk        (clk),
    .rst        (rst),
    .key_valid  (key_valid),
    .key_digit  (key_digit),
    .prog_req   (prog_req),
    .cancel     (cancel),
    .alarm_rst  (alarm_rst),
    .match      (match),
    .sp_shift   (sp_shift),
    .ui_shift   (ui_shift),
    .shift_data (shift_data),
    .sp_clr     (sp_clr),
    .ui_clr     (ui_clr),
    .mode       (mode),
    .digit_cnt  (digit_cnt),
    .attempt_bcd(attempt_bcd),
    .unlocked   (unlocked),
    .alarm      (alarm)
  );

  // External SP/UI shift arrays and equality comparator.
  assign match = (sp_arr == ui_arr);
  always @(posedge clk) begin
    if (sp_clr)        sp_arr <= '0;
    else if (sp_shift) sp_arr <= {sp_arr[27:0], shift_data};
    if (ui_clr)        ui_arr <= '0;
    else if (ui_shift) ui_arr <= {ui_arr[27:0], shift_data};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and check the shift/clear exclusivity rules.
  task automatic tick();
    @(negedge clk);
    chk("excl_sp_ui_shift", 32'(sp_shift & ui_shift), 0);
    chk("excl_sp_clr_shift", 32'(sp_clr & sp_shift), 0);
    chk("excl_ui_clr_shift", 32'(ui_clr & ui_shift), 0);
  endtask

  task automatic press(input logic [3:0] d);
    key_valid = 1'b1;
    key_digit = d;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic enter_code(input bit wrong);
    logic [3:0] d;
    for (int i = 0; i < 8; i++) begin
      d = (wrong && i == 7) ? 4'd7 : code[i];
      press(d);
      chk("entry_ui_shift", 32'(ui_shift), 1);
      chk("entry_data", 32'(shift_data), 32'(d));
      chk("entry_cnt", 32'(digit_cnt), i + 1);
      chk("entry_mode", 32'(mode), 1);
    end
  endtask

  task automatic program_code();
    for (int i = 0; i < 8; i++) begin
      press(code[i]);
      chk("prog_sp_shift", 32'(sp_shift), 1);
      chk("prog_ui_shift", 32'(ui_shift), 0);
      chk("prog_data", 32'(shift_data), 32'(code[i]));
      chk("prog_cnt", 32'(digit_cnt), (i == 7) ? 0 : i + 1);
    end
    chk("prog_done_mode", 32'(mode), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    code = '{4'd2, 4'd1, 4'd9, 4'd3, 4'd5, 4'd4, 4'd8, 4'd8};

    // Reset values
    tick();
    tick();
    chk("rst_sp_clr", 32'(sp_clr), 1);
    chk("rst_ui_clr", 32'(ui_clr), 1);
    chk("rst_mode", 32'(mode), 0);
    chk("rst_cnt", 32'(digit_cnt), 0);
    chk("rst_attempt", 32'(attempt_bcd), 0);
    chk("rst_unlocked", 32'(unlocked), 0);
    chk("rst_alarm", 32'(alarm), 0);
    chk("rst_sp_shift", 32'(sp_shift), 0);
    rst = 1'b0;
    tick();
    chk("post_rst_sp_clr", 32'(sp_clr), 0);
    chk("post_rst_ui_clr", 32'(ui_clr), 0);

    // 1: program the setpoint
    prog_req = 1'b1;
    tick();
    prog_req = 1'b0;
    chk("prog_mode", 32'(mode), 2);
    chk("prog_cnt0", 32'(digit_cnt), 0);
    program_code();
    tick();
    chk("armed_sp_shift", 32'(sp_shift), 0);

    // 2: correct entry, unlock hold of 16 cycles, relock
    enter_code(1'b0);
    chk("n1_unlocked", 32'(unlocked), 0);
    tick();
    chk("n2_unlocked", 32'(unlocked), 0);
    chk("n2_mode", 32'(mode), 0);
    tick();
    chk("n3_unlocked", 32'(unlocked), 1);
    chk("n3_attempt", 32'(attempt_bcd), 0);
    chk("n3_cnt", 32'(digit_cnt), 0);
    repeat (15) begin
      tick();
      chk("hold_unlocked", 32'(unlocked), 1);
    end
    tick();
    chk("relock_unlocked", 32'(unlocked), 0);
    chk("relock_ui_clr", 32'(ui_clr), 1);
    tick();
    chk("relock_ui_clr_end", 32'(ui_clr), 0);

    // 3: five wrong entries raise the alarm
    for (int k = 1; k <= 5; k++) begin
      enter_code(1'b1);
      tick();
      tick();
      chk("wrong_attempt", 32'(attempt_bcd), k);
      chk("wrong_ui_clr", 32'(ui_clr), 1);
      chk("wrong_unlocked", 32'(unlocked), 0);
      chk("wrong_alarm", 32'(alarm), 32'(k == 5));
    end
    press(4'd3);
    chk("alarm_key_ui_shift", 32'(ui_shift), 0);
    chk("alarm_key_sp_shift", 32'(sp_shift), 0);
    chk("alarm_key_cnt", 32'(digit_cnt), 0);
    prog_req = 1'b1;
    cancel = 1'b1;
    tick();
    prog_req = 1'b0;
    cancel = 1'b0;
    chk("alarm_prog_mode", 32'(mode), 0);
    chk("alarm_held", 32'(alarm), 1);
    chk("alarm_sp_clr", 32'(sp_clr), 0);
    chk("alarm_attempt", 32'(attempt_bcd), 5);

    // 4: alarm_rst, correct entry unlocks, reprogram from UNLOCKED
    alarm_rst = 1'b1;
    tick();
    alarm_rst = 1'b0;
    chk("arst_alarm", 32'(alarm), 0);
    chk("arst_attempt", 32'(attempt_bcd), 0);
    chk("arst_ui_clr", 32'(ui_clr), 1);
    enter_code(1'b0);
    tick();
    tick();
    chk("arst_unlock", 32'(unlocked), 1);
    prog_req = 1'b1;
    tick();
    prog_req = 1'b0;
    chk("reprog_sp_clr", 32'(sp_clr), 1);
    chk("reprog_ui_clr", 32'(ui_clr), 1);
    chk("reprog_unlocked", 32'(unlocked), 0);
    chk("reprog_mode", 32'(mode), 2);
    program_code();

    // 5: cancel during entry with a simultaneous key
    enter_code(1'b1);
    tick();
    tick();
    chk("pre_cancel_attempt", 32'(attempt_bcd), 1);
    for (int i = 0; i < 3; i++) press(code[i]);
    chk("pre_cancel_cnt", 32'(digit_cnt), 3);
    cancel = 1'b1;
    key_valid = 1'b1;
    key_digit = 4'd5;
    tick();
    cancel = 1'b0;
    key_valid = 1'b0;
    chk("cancel_ui_clr", 32'(ui_clr), 1);
    chk("cancel_ui_shift", 32'(ui_shift), 0);
    chk("cancel_cnt", 32'(digit_cnt), 0);
    chk("cancel_mode", 32'(mode), 0);
    chk("cancel_attempt", 32'(attempt_bcd), 1);
    enter_code(1'b0);
    tick();
    tick();
    chk("post_cancel_unlock", 32'(unlocked), 1);
    chk("post_cancel_attempt", 32'(attempt_bcd), 0);
    repeat (15) tick();
    tick();
    chk("post_cancel_relock", 32'(unlocked), 0);

    // 6: non-BCD keys, keys during CHECK, reset mid-PROG
    press(4'hA);
    chk("hexA_armed_shift", 32'(ui_shift), 0);
    chk("hexA_armed_mode", 32'(mode), 0);
    for (int i = 0; i < 4; i++) press(code[i]);
    press(4'hA);
    chk("hexA_entry_shift", 32'(ui_shift), 0);
    chk("hexA_entry_cnt", 32'(digit_cnt), 4);
    for (int i = 4; i < 8; i++) press(code[i]);
    chk("full_cnt", 32'(digit_cnt), 8);
    tick();
    key_valid = 1'b1;
    key_digit = 4'd3;
    tick();
    key_valid = 1'b0;
    chk("check_key_shift", 32'(ui_shift), 0);
    chk("check_key_unlock", 32'(unlocked), 1);
    prog_req = 1'b1;
    tick();
    prog_req = 1'b0;
    chk("midprog_mode", 32'(mode), 2);
    press(4'd6);
    press(4'd6);
    chk("midprog_cnt", 32'(digit_cnt), 2);
    rst = 1'b1;
    tick();
    chk("midrst_sp_clr", 32'(sp_clr), 1);
    chk("midrst_ui_clr", 32'(ui_clr), 1);
    chk("midrst_cnt", 32'(digit_cnt), 0);
    chk("midrst_mode", 32'(mode), 0);
    chk("midrst_sp_shift", 32'(sp_shift), 0);
    rst = 1'b0;
    tick();
    chk("midrst_clr_end", 32'(sp_clr), 0);
    press(4'd4);
    chk("idle_key_shift", 32'(sp_shift | ui_shift), 0);
    chk("idle_key_mode", 32'(mode), 0);
    prog_req = 1'b1;
    tick();
    prog_req = 1'b0;
    chk("idle_prog_mode", 32'(mode), 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
